reg_load_arbiter: RTL
=====================

// Module: reg_load_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for a shared 32-bit load/hold data register.
//  Collects write requests from NUM_REQ masters over valid/ready.
//  Grants one master at a time and drives the register's load strobe.
//  Otherwise the register holds its previous value.
//  Sits between the datapath masters and the register-A storage element.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..8)
//  DATA_W    32   register/data bus width
//  MAX_LOCK  4    max consecutive beats under lock (REG_ARB_LOCK_EN only, 1..15)
// PORTS
//  clk        in   1                  single clock, all flops on rising edge
//  rst_n      in   1                  reset, asynchronous assert, active-low
//  req_valid  in   NUM_REQ            requester i has a write pending
//  req_data   in   NUM_REQ*DATA_W     flat data, slice i = [i*DATA_W +: DATA_W]
//  req_lock   in   NUM_REQ            request to keep grant (ignored without macro)
//  req_ready  out  NUM_REQ            one-hot accept; transfer when valid&ready
//  data_out   out  DATA_W             current register contents
//  data_vld   out  1                  high once any write has completed since reset
//  owner_id   out  $clog2(NUM_REQ)    index of last master that wrote data_out
//  load_done  out  1                  1-cycle pulse, the cycle data_out updates
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, rr_ptr=0, data_out=0, data_vld=0,
//    owner_id=0, load_done=0, req_ready=0, lock_cnt=0.
//  - FSM states: IDLE, LOAD.
//  - IDLE: winner = first i with req_valid[i], searched from rr_ptr upward,
//    wrapping NUM_REQ-1 -> 0.
//    - req_ready[winner]=1 combinationally; all other ready bits 0.
//    - On the edge: capture req_data slice and winner index, go to LOAD.
//    - No valid: req_ready=0, stay in IDLE.
//  - LOAD: register load strobe=1 for exactly one cycle; req_ready=0.
//    - On the edge: data_out<=captured data, owner_id<=winner, data_vld<=1.
//    - load_done=1 in the cycle after that edge; rr_ptr<=winner+1 (mod NUM_REQ).
//    - Return to IDLE.
//  - Latency: accept at edge k; data_out valid after edge k+1. Peak rate 1 write / 2 cycles.
//  - Hold: no load strobe -> data_out unchanged indefinitely.
//  - Fairness: a requester that stays valid is served within NUM_REQ grants.
//  - valid may drop before ready without penalty; data is sampled only at valid&ready.
//  - rst_n mid-LOAD: write discarded, data_out=0, all outputs to reset values.
// CONFIGURATION
//  - REG_ARB_LOCK_EN defined, on a grant with req_lock[winner]=1:
//    - rr_ptr is not advanced, so the same master wins the next IDLE if still valid.
//    - lock_cnt counts consecutive locked beats.
//    - At MAX_LOCK beats, or when the master is not valid in IDLE, lock_cnt clears
//      and rr_ptr advances normally.
//  - REG_ARB_LOCK_EN undefined: req_lock unused, lock_cnt absent, pure round-robin.
// STRUCTURE
//  - Package reg_arb_pkg: state enum (IDLE, LOAD), DATA_W default, owner index typedef.
//  - Sub-module reg_a_core: clk, rst_n, load, din, dout; load/hold register with
//    async reset to 0.
//  - Arbitration and the FSM stay in reg_load_arbiter.
// TESTING
//  1. Reset: assert rst_n=0 mid-run -> data_out=0, data_vld=0, req_ready=0
//     immediately (async).
//  2. Single write: req_valid=4'b0010, data 0xDEADBEEF
//     -> req_ready[1] at cycle 0; data_out=0xDEADBEEF, owner_id=1, load_done=1 at cycle 2.
//  3. Round-robin: all 4 valid continuously -> owner_id sequence 0,1,2,3,0.
//     Each write lands every 2 cycles.
//  4. Hold: no requests for 20 cycles after write 0x12345678
//     -> data_out stays 0x12345678, load_done=0.
//  5. Wrap/skip: rr_ptr=3, only req 1 valid -> grant 1; next rr_ptr=2.
//  6. Lock (REG_ARB_LOCK_EN, MAX_LOCK=4): req 2 locked, all valid
//     -> owner 2 four times, then owner 3.

Source files
------------

// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_arb_pkg
//  Description : Shared types and constants for the register-A load arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_arb_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_IDX_W  = 3;

    // Wide enough for the largest supported requester count (8).
    typedef logic [c_IDX_W-1:0] ownerIdx_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } arbState_t;

endpackage
`default_nettype wire

// File: rtl/reg_load_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_load_arbiter_if
//  Description : Requester bundle and register-A status for the load arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_load_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = c_DATA_W
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         data_out;
    logic                      data_vld;
    logic [IDX_W-1:0]          owner_id;
    logic                      load_done;

    modport master (
        output req_valid, req_data, req_lock,
        input  req_ready, data_out, data_vld, owner_id, load_done
    );

    modport slave (
        input  req_valid, req_data, req_lock,
        output req_ready, data_out, data_vld, owner_id, load_done
    );

endinterface
`default_nettype wire

// File: rtl/reg_a_core.sv
`default_nettype none
// ============================================================================
//  Module      : reg_a_core
//  Description : Load/hold data register with asynchronous clear to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_a_core
    import reg_arb_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= din;
        end
    end

    assign dout = r_q;

endmodule
`default_nettype wire

// File: rtl/reg_load_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_load_arbiter
//  Description : Round-robin arbiter/sequencer driving the register-A load
//                strobe. Optional grant locking enabled by REG_ARB_LOCK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_load_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = c_DATA_W,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_load_arbiter_if.slave bus
);

    localparam int        IDX_W  = $clog2(NUM_REQ);
    localparam ownerIdx_t c_LAST = ownerIdx_t'(NUM_REQ - 1);

    arbState_t          r_state;
    arbState_t          w_nextState;
    ownerIdx_t          r_rrPtr;
    ownerIdx_t          r_winner;
    ownerIdx_t          w_winner;
    ownerIdx_t          w_upIdx;
    ownerIdx_t          w_anyIdx;
    ownerIdx_t          w_advPtr;
    ownerIdx_t          w_nextPtr;
    logic               w_upFound;
    logic               w_anyFound;
    logic               w_found;
    logic               w_load;
    logic               w_winLock;
    logic [NUM_REQ-1:0] w_ready;
    logic [DATA_W-1:0]  w_winData;
    logic [DATA_W-1:0]  r_capData;
    logic [DATA_W-1:0]  w_dataOut;
    logic               r_dataVld;
    logic               r_loadDone;
    logic [IDX_W-1:0]   r_ownerId;

    // Descending scan leaves the lowest index in each class; indices at or
    // above the pointer take precedence over the wrapped-around ones.
    always_comb begin
        w_upFound  = 1'b0;
        w_anyFound = 1'b0;
        w_upIdx    = '0;
        w_anyIdx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                w_anyFound = 1'b1;
                w_anyIdx   = ownerIdx_t'(i);
                if (ownerIdx_t'(i) >= r_rrPtr) begin
                    w_upFound = 1'b1;
                    w_upIdx   = ownerIdx_t'(i);
                end
            end
        end
        w_found  = w_anyFound;
        w_winner = w_upFound ? w_upIdx : w_anyIdx;
    end

    always_comb begin
        w_winData = '0;
        w_winLock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ownerIdx_t'(i)) begin
                w_winData = bus.req_data[i*DATA_W +: DATA_W];
                w_winLock = bus.req_lock[i];
            end
        end
    end

    assign w_advPtr = (r_winner == c_LAST) ? '0 : r_winner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_found) w_nextState = LOAD;
            LOAD:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Ready is held low while reset is asserted, even though the state is IDLE.
    always_comb begin
        w_load  = (r_state == LOAD);
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = rst_n && (r_state == IDLE) && w_found
                         && (w_winner == ownerIdx_t'(i));
        end
    end

`ifdef REG_ARB_LOCK_EN
    localparam logic [3:0] c_MAX_LOCK = 4'(MAX_LOCK);

    logic       r_capLock;
    logic [3:0] r_lockCnt;
    logic [3:0] w_lockBeats;
    logic [3:0] w_nextLockCnt;

    // A locked grant pins the pointer on the winner until MAX_LOCK beats.
    always_comb begin
        w_lockBeats = ((r_lockCnt != 4'd0) && (r_winner[IDX_W-1:0] == r_ownerId))
                      ? r_lockCnt + 4'd1 : 4'd1;
        if (r_capLock && (w_lockBeats < c_MAX_LOCK)) begin
            w_nextPtr     = r_winner;
            w_nextLockCnt = w_lockBeats;
        end else begin
            w_nextPtr     = w_advPtr;
            w_nextLockCnt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_capLock <= 1'b0;
            r_lockCnt <= '0;
        end else if ((r_state == IDLE) && w_found) begin
            r_capLock <= w_winLock;
        end else if (r_state == LOAD) begin
            r_lockCnt <= w_nextLockCnt;
        end
    end
`else
    logic w_unusedLock;

    assign w_unusedLock = ^{bus.req_lock, w_winLock, MAX_LOCK};
    assign w_nextPtr    = w_advPtr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_capData  <= '0;
            r_winner   <= '0;
            r_rrPtr    <= '0;
            r_ownerId  <= '0;
            r_dataVld  <= 1'b0;
            r_loadDone <= 1'b0;
        end else begin
            r_loadDone <= (r_state == LOAD);
            if ((r_state == IDLE) && w_found) begin
                r_capData <= w_winData;
                r_winner  <= w_winner;
            end
            if (r_state == LOAD) begin
                r_ownerId <= r_winner[IDX_W-1:0];
                r_dataVld <= 1'b1;
                r_rrPtr   <= w_nextPtr;
            end
        end
    end

    reg_a_core #(
        .DATA_W (DATA_W)
    ) u_regA (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .din   (r_capData),
        .dout  (w_dataOut)
    );

    assign bus.req_ready = w_ready;
    assign bus.data_out  = w_dataOut;
    assign bus.data_vld  = r_dataVld;
    assign bus.owner_id  = r_ownerId;
    assign bus.load_done = r_loadDone;

endmodule
`default_nettype wire
